// File: rtl/slave_in.sv
`default_nettype none
// ============================================================================
//  Module      : slave_in
//  Description : Slave-side serial receiver. Deserialises the master's
//                LSB-first address, burst number and write data, handshakes
//                with master_valid/slave_ready, and issues one-cycle memory
//                strobes per burst beat with an auto-incrementing address.
//  Ports       : clk, reset (async, active-low)
//                slave_sel, write_en, read_en      - request from decoder/master
//                master_valid, rx_address,
//                rx_burst_number, rx_data          - serial bit stream
//                tx_beat_done                      - read-return beat finished
//                slave_ready                       - accepting serial bits
//                mem_address, mem_wdata,
//                mem_write, mem_read               - slave memory interface
//                rx_done, rx_abort                 - one-cycle status pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module slave_in #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  slave_sel,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic                  master_valid,
    input  logic                  rx_address,
    input  logic                  rx_burst_number,
    input  logic                  rx_data,
    input  logic                  tx_beat_done,
    output logic                  slave_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic                  rx_done,
    output logic                  rx_abort
);

    // Bit counter must reach the longer of the header and the data beat.
    localparam int c_cnt_w = $clog2((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 1;

    localparam logic [c_cnt_w-1:0]     c_hdr_last  = c_cnt_w'(ADDR_WIDTH - 1);
    localparam logic [c_cnt_w-1:0]     c_data_last = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0]     c_data_bits = c_cnt_w'(DATA_WIDTH);
    localparam logic [BURST_WIDTH:0]   c_one_beat  = (BURST_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0]  c_addr_one  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READY   = 3'd1,
        S_HDR     = 3'd2,
        S_EXEC    = 3'd3,
        S_RX_DATA = 3'd4,
        S_WAIT_RD = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_is_write;
    logic [ADDR_WIDTH-1:0]   r_addr_sh;
    logic [BURST_WIDTH-1:0]  r_burst_sh;
    logic [DATA_WIDTH-1:0]   r_data_sh;
    logic [c_cnt_w-1:0]      r_bit_cnt;
    logic [BURST_WIDTH:0]    r_beats_left;
    logic [ADDR_WIDTH-1:0]   r_mem_address;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic                    r_abort;

    logic                    w_active;
    logic                    w_abort;
    logic                    w_sample;
    logic                    w_in_hdr;
    logic                    w_hdr_last;
    logic                    w_rx_last;
    logic                    w_rd_go;
    logic                    w_exec_entry;
    logic [ADDR_WIDTH-1:0]   w_addr_shifted;
    logic [BURST_WIDTH-1:0]  w_burst_shifted;
    logic [DATA_WIDTH-1:0]   w_data_shifted;
    logic [DATA_WIDTH-1:0]   w_hdr_data;
    logic [DATA_WIDTH-1:0]   w_beat_data;

    // Handshake and strobes are pure decodes of the state register, so they
    // are glitch-free and drop to zero the instant reset is asserted.
    assign slave_ready = (r_state == S_READY) || (r_state == S_HDR) || (r_state == S_RX_DATA);
    assign mem_write   = (r_state == S_EXEC) && r_is_write;
    assign mem_read    = (r_state == S_EXEC) && !r_is_write;
    assign rx_done     = (r_state == S_DONE);
    assign rx_abort    = r_abort;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;

    assign w_active = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_abort  = w_active && !slave_sel;
    // Deselect wins over a bit offered in the same cycle.
    assign w_sample = slave_ready && master_valid && slave_sel;
    assign w_in_hdr = (r_state == S_READY) || (r_state == S_HDR);

    // LSB-first: each new bit enters at the MSB and walks down.
    assign w_addr_shifted  = {rx_address, r_addr_sh[ADDR_WIDTH-1:1]};
    assign w_burst_shifted = {rx_burst_number, r_burst_sh[BURST_WIDTH-1:1]};
    assign w_data_shifted  = {rx_data, r_data_sh[DATA_WIDTH-1:1]};

    assign w_hdr_last   = (r_state == S_HDR) && w_sample && (r_bit_cnt == c_hdr_last);
    assign w_rx_last    = (r_state == S_RX_DATA) && w_sample && (r_bit_cnt == c_data_last);
    assign w_rd_go      = (r_state == S_WAIT_RD) && slave_sel && tx_beat_done;
    assign w_exec_entry = w_hdr_last || w_rx_last || w_rd_go;

    // Beat-0 data rides in the first DATA_WIDTH header samples; if the final
    // header sample is still a data bit it must be folded in here.
    assign w_hdr_data  = (r_bit_cnt < c_data_bits) ? w_data_shifted : r_data_sh;
    assign w_beat_data = w_hdr_last ? w_hdr_data : w_data_shifted;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (slave_sel && (write_en ^ read_en)) w_next_state = S_READY;
            end
            S_READY: begin
                if (w_abort)       w_next_state = S_IDLE;
                else if (w_sample) w_next_state = S_HDR;
            end
            S_HDR: begin
                if (w_abort)         w_next_state = S_IDLE;
                else if (w_hdr_last) w_next_state = S_EXEC;
            end
            S_EXEC: begin
                if (w_abort)                         w_next_state = S_IDLE;
                else if (r_beats_left == c_one_beat) w_next_state = S_DONE;
                else if (r_is_write)                 w_next_state = S_RX_DATA;
                else                                 w_next_state = S_WAIT_RD;
            end
            S_RX_DATA: begin
                if (w_abort)        w_next_state = S_IDLE;
                else if (w_rx_last) w_next_state = S_EXEC;
            end
            S_WAIT_RD: begin
                if (w_abort)      w_next_state = S_IDLE;
                else if (w_rd_go) w_next_state = S_EXEC;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_is_write    <= 1'b0;
            r_addr_sh     <= '0;
            r_burst_sh    <= '0;
            r_data_sh     <= '0;
            r_bit_cnt     <= '0;
            r_beats_left  <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_abort       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_abort <= w_abort;

            // Operation is frozen once the request has been accepted.
            if ((r_state == S_IDLE) && (w_next_state == S_READY)) r_is_write <= write_en;

            // Header counting starts from IDLE; each data beat restarts after EXEC.
            if ((r_state == S_IDLE) || (r_state == S_EXEC)) r_bit_cnt <= '0;
            else if (w_sample)                             r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_sample && w_in_hdr) begin
                r_addr_sh  <= w_addr_shifted;
                r_burst_sh <= w_burst_shifted;
                if (r_bit_cnt < c_data_bits) r_data_sh <= w_data_shifted;
            end
            if (w_sample && (r_state == S_RX_DATA)) r_data_sh <= w_data_shifted;

            // One extra bit so burst 0xFFF gives 4096 beats without overflow.
            if (w_hdr_last)                r_beats_left <= {1'b0, w_burst_shifted} + c_one_beat;
            else if (r_state == S_EXEC)    r_beats_left <= r_beats_left - c_one_beat;

            // Memory-side address/data are loaded on the way into EXEC so they
            // are valid during the strobe and hold afterwards. Later beats use
            // the previous beat address + 1, wrapping naturally at the width.
            if (w_exec_entry) begin
                r_mem_address <= w_hdr_last ? w_addr_shifted : (r_mem_address + c_addr_one);
                if (r_is_write) r_mem_wdata <= w_beat_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slave_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slave_in
//  Description : Self-checking bench for slave_in. Table of directed
//                transactions plus hand-written stall, abort, illegal-request
//                and asynchronous-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_in;

    logic        clk;
    logic        reset;
    logic        slave_sel;
    logic        write_en;
    logic        read_en;
    logic        master_valid;
    logic        rx_address;
    logic        rx_burst_number;
    logic        rx_data;
    logic        tx_beat_done;
    logic        slave_ready;
    logic [11:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic        rx_done;
    logic        rx_abort;

    slave_in #(
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (8),
        .BURST_WIDTH (12)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .slave_sel       (slave_sel),
        .write_en        (write_en),
        .read_en         (read_en),
        .master_valid    (master_valid),
        .rx_address      (rx_address),
        .rx_burst_number (rx_burst_number),
        .rx_data         (rx_data),
        .tx_beat_done    (tx_beat_done),
        .slave_ready     (slave_ready),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .rx_done         (rx_done),
        .rx_abort        (rx_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [7:0]  data;
        int          cyc;
    } ev_t;

    ev_t ev_q[$];
    int  done_q[$];
    int  abort_cnt = 0;
    int  b2b_cnt   = 0;
    bit  prev_read = 1'b0;

    // Passive monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_write || mem_read) begin
                ev_t e;
                e.wr   = mem_write;
                e.addr = mem_address;
                e.data = mem_wdata;
                e.cyc  = cyc;
                ev_q.push_back(e);
            end
            if (mem_read && prev_read) b2b_cnt++;
            prev_read = mem_read;
            if (rx_done)  done_q.push_back(cyc);
            if (rx_abort) abort_cnt++;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int t_first = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit               wr;
        logic [11:0]      addr;
        logic [11:0]      burst;
        logic [3:0][7:0]  data;
        logic [3:0][11:0] exp_addr;
        int               beats;
    } vec_t;

    vec_t vecs [5];

    // Request, then present the 12 header bits. Optional stall after bit
    // stall_after, optional deselect at bit abort_at.
    task automatic send_header(input bit wr, input logic [11:0] addr, input logic [11:0] burst,
                               input logic [7:0] d0, input int stall_after, input int stall_len,
                               input int abort_at);
        bit stop;
        stop      = 1'b0;
        slave_sel = 1'b1;
        write_en  = wr;
        read_en   = !wr;
        tick();
        write_en  = 1'b0;
        read_en   = 1'b0;
        t_first   = cyc;
        for (int i = 0; i < 12 && !stop; i++) begin
            master_valid    = 1'b1;
            rx_address      = addr[i];
            rx_burst_number = burst[i];
            rx_data         = (wr && i < 8) ? d0[i] : 1'b0;
            if (i == abort_at) slave_sel = 1'b0;
            tick();
            if (i == abort_at) stop = 1'b1;
            if (i == stall_after) begin
                master_valid = 1'b0;
                tx_beat_done = 1'b1;
                repeat (stall_len) tick();
                tx_beat_done = 1'b0;
            end
        end
        master_valid    = 1'b0;
        rx_address      = 1'b0;
        rx_burst_number = 1'b0;
        rx_data         = 1'b0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (mem_write || mem_read) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL strobe_timeout: no mem strobe within 40 cycles, required one");
        end
    endtask

    task automatic send_byte(input logic [7:0] d, output bit ok);
        int k;
        ok = 1'b1;
        for (int i = 0; i < 8 && ok; i++) begin
            k = 0;
            while (!slave_ready && k < 20) begin
                tick();
                k++;
            end
            if (!slave_ready) begin
                ok = 1'b0;
                n_cmp++;
                n_fail++;
                $display("FAIL ready_timeout: slave_ready=0 for 20 cycles, required 1");
            end else begin
                master_valid = 1'b1;
                rx_data      = d[i];
                tick();
            end
        end
        master_valid = 1'b0;
        rx_data      = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int stall_after, input int stall_len);
        int n0, d0, n;
        bit ok, ready_hdr;
        ev_t e;
        n0 = ev_q.size();
        d0 = done_q.size();
        send_header(v.wr, v.addr, v.burst, v.data[0], stall_after, stall_len, -1);
        ready_hdr = slave_ready;
        ok = 1'b1;
        for (int b = 0; b < v.beats && ok; b++) begin
            wait_strobe(ok);
            if (ok && b < v.beats - 1) begin
                tick();
                if (v.wr) send_byte(v.data[b+1], ok);
                else begin
                    tick();
                    tx_beat_done = 1'b1;
                    tick();
                    tx_beat_done = 1'b0;
                end
            end
        end
        tick();
        tick();
        n = ev_q.size() - n0;
        check("ready_low_after_hdr", ready_hdr, 0);
        check("beat_count", n, v.beats);
        for (int b = 0; b < n && b < v.beats; b++) begin
            e = ev_q[n0 + b];
            check("strobe_kind", e.wr, v.wr);
            check("beat_addr", e.addr, v.exp_addr[b]);
            if (v.wr) check("beat_data", e.data, v.data[b]);
            if (b == 0) check("hdr_latency", e.cyc - t_first, 12 + stall_len);
            else        check("beat_gap", e.cyc - ev_q[n0 + b - 1].cyc, v.wr ? 9 : 3);
        end
        check("done_count", done_q.size() - d0, 1);
        if (done_q.size() > d0 && n > 0)
            check("done_latency", done_q[d0] - ev_q[n0 + n - 1].cyc, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0, a0;
        bit  ok, ready_seen;

        vecs[0] = '{1'b1, 12'h553, 12'h000, {8'h00, 8'h00, 8'h00, 8'hA5},
                    {12'h000, 12'h000, 12'h000, 12'h553}, 1};
        vecs[1] = '{1'b0, 12'h553, 12'h003, {8'h00, 8'h00, 8'h00, 8'h00},
                    {12'h556, 12'h555, 12'h554, 12'h553}, 4};
        vecs[2] = '{1'b1, 12'hFFF, 12'h001, {8'h00, 8'h00, 8'h22, 8'h11},
                    {12'h000, 12'h000, 12'h000, 12'hFFF}, 2};
        vecs[3] = '{1'b1, 12'h0AA, 12'h002, {8'h00, 8'h7E, 8'hC3, 8'h3C},
                    {12'h000, 12'h0AC, 12'h0AB, 12'h0AA}, 3};
        vecs[4] = '{1'b0, 12'hFFE, 12'h002, {8'h00, 8'h00, 8'h00, 8'h00},
                    {12'h000, 12'h000, 12'hFFF, 12'hFFE}, 3};

        reset           = 1'b0;
        slave_sel       = 1'b0;
        write_en        = 1'b0;
        read_en         = 1'b0;
        master_valid    = 1'b0;
        rx_address      = 1'b0;
        rx_burst_number = 1'b0;
        rx_data         = 1'b0;
        tx_beat_done    = 1'b0;
        tick();
        tick();
        check("reset_ready", slave_ready, 0);
        check("reset_strobes", {mem_write, mem_read, rx_done, rx_abort}, 0);
        check("reset_addr_data", {mem_address, mem_wdata}, 0);
        reset = 1'b1;
        tick();

        // Table of complete transactions.
        for (int v = 0; v < 5; v++) run_txn(vecs[v], -1, 0);

        // Stall after header bit 5 for 3 cycles; tx_beat_done pulsed meanwhile.
        run_txn(vecs[0], 5, 3);

        // Deselect at header bit 7.
        n0 = ev_q.size();
        a0 = abort_cnt;
        send_header(1'b1, 12'h553, 12'h000, 8'hA5, -1, 0, 7);
        check("abort_pulse", rx_abort, 1);
        check("abort_ready", slave_ready, 0);
        tick();
        check("abort_pulse_width", rx_abort, 0);
        repeat (5) tick();
        check("abort_no_strobe", ev_q.size() - n0, 0);
        check("abort_count", abort_cnt - a0, 1);

        // Both write_en and read_en high: request must be refused.
        n0 = ev_q.size();
        slave_sel  = 1'b1;
        write_en   = 1'b1;
        read_en    = 1'b1;
        ready_seen = 1'b0;
        repeat (5) begin
            tick();
            ready_seen = ready_seen | slave_ready;
        end
        check("illegal_ready", ready_seen, 0);
        check("illegal_no_strobe", ev_q.size() - n0, 0);
        run_txn(vecs[3], -1, 0);

        // Asynchronous reset in the middle of a write burst.
        send_header(1'b1, 12'h2C4, 12'h001, 8'h99, -1, 0, -1);
        wait_strobe(ok);
        tick();
        check("pre_reset_ready", slave_ready, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs",
              {slave_ready, mem_address, mem_wdata, mem_write, mem_read, rx_done, rx_abort}, 0);
        slave_sel    = 1'b0;
        master_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        run_txn(vecs[0], -1, 0);

        check("no_back_to_back_reads", b2b_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slave_in.md
Name: slave_in

Overview:
Slave-side serial receiver, directly downstream of the bus master transmitter via the arbiter/decoder. Deserializes the master's bit-serial address, burst number and write data, and handshakes with master_valid/slave_ready. Issues parallel single-cycle write/read strobes to the local slave memory for every burst beat with an auto-incrementing address, then signals rx_done.

Parameters:
ADDR_WIDTH, 12, width of address and of address shift register
DATA_WIDTH, 8, width of one data beat
BURST_WIDTH, 12, width of burst number field

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
slave_sel  input  1  decoder: this slave addressed by granted master
write_en  input  1  master write request
read_en  input  1  master read request
master_valid  input  1  serial bits valid this cycle
rx_address  input  1  serial address, LSB first
rx_burst_number  input  1  serial burst number, LSB first
rx_data  input  1  serial write data, LSB first
tx_beat_done  input  1  slave read-return serializer finished current beat
slave_ready  output  1  slave accepting serial bits
mem_address  output  ADDR_WIDTH  beat address to slave memory
mem_wdata  output  DATA_WIDTH  write data to slave memory
mem_write  output  1  one-cycle write strobe
mem_read  output  1  one-cycle read strobe
rx_done  output  1  one-cycle transaction-complete pulse
rx_abort  output  1  one-cycle abort pulse

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs, shift registers, bit and beat counters 0.
- Bit sample: a bit is taken only in cycles with master_valid=1 AND slave_ready=1; master_valid=0 stalls, counters hold.
- States: IDLE, READY, HDR, EXEC, RX_DATA, WAIT_RD, DONE.
- IDLE: slave_ready=0. slave_sel=1 with exactly one of write_en/read_en -> READY; latch op. Both or neither high -> stay IDLE.
- READY: slave_ready=1 (registered, first high cycle after leaving IDLE). First sampled bit -> HDR, counting that bit as bit 0.
- HDR: ADDR_WIDTH sampled bits; rx_address and rx_burst_number shifted concurrently, bit i at sample i. For write, rx_data sampled on samples 0..DATA_WIDTH-1 as beat-0 data. After sample ADDR_WIDTH-1: slave_ready=0, beats_left = burst_number+1 (BURST_WIDTH+1 bits), -> EXEC.
- EXEC (1 cycle): mem_address=current address; write: mem_write=1, mem_wdata=beat data; read: mem_read=1. Decrement beats_left, increment address modulo 2^ADDR_WIDTH (0xFFF -> 0x000). Then beats_left=0 -> DONE; else write -> RX_DATA, read -> WAIT_RD.
- RX_DATA: slave_ready=1; DATA_WIDTH sampled rx_data bits -> EXEC.
- WAIT_RD: slave_ready=0; tx_beat_done=1 -> EXEC next cycle. tx_beat_done outside WAIT_RD ignored.
- DONE: rx_done=1 for one cycle -> IDLE. slave_ready low.
- mem_address/mem_wdata hold last values outside EXEC; strobes are exactly one cycle per beat.
- Abort: slave_sel=0 in any state except IDLE/DONE -> rx_abort=1 one cycle, slave_ready=0, no further strobes, -> IDLE. Abort has priority over bit sampling in the same cycle.
- write_en/read_en changes after leaving IDLE ignored (op latched).
- Burst 0 = 1 beat; burst 0xFFF = 4096 beats, address wraps.
- Latency: last header bit sampled -> mem strobe next cycle; last beat strobe -> rx_done next cycle.

Test Plan:
- Single write: slave_sel=1, write_en=1, address 0x553, burst 0, data 0xA5 over 12 valid cycles -> exactly one mem_write with mem_address=0x553, mem_wdata=0xA5, one cycle after 12th bit; rx_done one cycle later.
- Read burst: read_en=1, address 0x553, burst 3, tx_beat_done pulsed 2 cycles after each strobe -> mem_read at 0x553, 0x554, 0x555, 0x556, never back-to-back without tx_beat_done; rx_done once after the 4th strobe.
- Wrap: write address 0xFFF, burst 1, data 0x11 then 0x22 -> writes (0xFFF,0x11), (0x000,0x22); slave_ready low between header end and RX_DATA.
- Stall: master_valid low for 3 cycles after bit 5 of header -> decoded address/burst identical to the unstalled run; strobe delayed exactly 3 cycles.
- Abort and reset: slave_sel dropped at header bit 7 -> rx_abort pulse, no strobe, IDLE. reset=0 mid-burst -> all outputs 0 immediately, asynchronously to clk. Next transaction completes normally.
- Illegal request: write_en=read_en=1 with slave_sel=1 -> slave_ready stays 0, no strobes; after read_en drops, write proceeds.
